// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared widths, constants and state type for the fetch stage
package instr_fetch_pkg;
  localparam int INST_SIZE = 32;
  localparam int DATA_SIZE = 32;
  localparam logic [DATA_SIZE-1:0] PC_STEP   = 32'd4;
  localparam logic [INST_SIZE-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } t_fetch_state;
endpackage

// File: rtl/instr_fetch_fifo.sv
// rtl/instr_fetch_fifo.sv - small {pc, instr} buffer with registered head and flush
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_pop;
  logic             w_do_push;

  function automatic logic [AW-1:0] f_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // Storage, pointers and occupancy; flush empties the buffer in one edge
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= f_next(r_wr_ptr);
      end
      if (w_do_pop) r_rd_ptr <= f_next(r_rd_ptr);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
      else if (!w_do_push && w_do_pop) r_count <= r_count - CW'(1);
    end
  end
endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage: PC, in-order imem requests, redirect flush, decode handshake
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [DATA_SIZE-1:0] RESET_PC   = 32'h0000_0000,
  parameter int                   FIFO_DEPTH = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  output logic                 o_imem_req,
  output logic [DATA_SIZE-1:0] o_imem_addr,
  input  logic                 i_imem_gnt,
  input  logic                 i_imem_rvalid,
  input  logic [INST_SIZE-1:0] i_imem_rdata,
  input  logic                 i_redirect,
  input  logic [DATA_SIZE-1:0] i_redirect_pc,
  output logic                 o_dec_valid,
  input  logic                 i_dec_ready,
  output logic [INST_SIZE-1:0] o_instr,
  output logic [DATA_SIZE-1:0] o_pc
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = CW + 1;

  t_fetch_state         r_state;
  t_fetch_state         w_state_nxt;
  logic [DATA_SIZE-1:0] r_pc;
  logic [DATA_SIZE-1:0] w_pc_nxt;
  logic [CW-1:0]        r_out;
  logic [CW-1:0]        r_drop;
  logic [CW-1:0]        w_out_nxt;
  logic [CW-1:0]        w_drop_nxt;
  logic [CW-1:0]        w_occ;
  logic                 w_pop;
  logic                 w_req;
  logic                 w_fire;
  logic                 w_rv;
  logic                 w_flush;
  logic                 w_push;
  logic [DATA_SIZE-1:0] w_rsp_pc;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic [DATA_SIZE+INST_SIZE-1:0] w_fifo_dout;

  // Request gating, response routing and next-state/PC/drop selection
  always_comb begin
    w_pop    = o_dec_valid & i_dec_ready;
    // Budget counts slots already promised: in flight plus buffered, minus the one leaving now
    w_req    = (r_state == FETCH) &&
               ((SW'(r_out) + SW'(w_occ) - SW'(w_pop)) < SW'(FIFO_DEPTH));
    w_fire   = w_req & i_imem_gnt;
    w_rv     = i_imem_rvalid & (r_out != '0);
    w_out_nxt = r_out + CW'(w_fire) - CW'(w_rv);
    // Outstanding requests are consecutive words ending just below the current PC
    w_rsp_pc = r_pc - (DATA_SIZE'(r_out) << 2);
    w_flush  = i_redirect & (r_state != IDLE);
    w_push   = w_rv & (r_state == FETCH) & (r_drop == '0) & ~w_flush;

    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_drop_nxt  = r_drop;
    if (w_fire) w_pc_nxt = r_pc + PC_STEP;
    case (r_state)
      IDLE:  w_state_nxt = FETCH;
      FETCH: w_state_nxt = FETCH;
      FLUSH: begin
        if (w_rv) w_drop_nxt = r_drop - CW'(1);
        if (w_drop_nxt == '0) w_state_nxt = FETCH;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_flush) begin
      w_pc_nxt    = {i_redirect_pc[DATA_SIZE-1:2], 2'b00};
      w_drop_nxt  = w_out_nxt;
      w_state_nxt = (w_out_nxt != '0) ? FLUSH : FETCH;
    end
  end

  // FSM state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // PC, in-flight request count and pending-discard count
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pc   <= RESET_PC;
      r_out  <= '0;
      r_drop <= '0;
    end else begin
      r_pc   <= w_pc_nxt;
      r_out  <= w_out_nxt;
      r_drop <= w_drop_nxt;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_SIZE + INST_SIZE)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (w_push),
    .i_push_data ({w_rsp_pc, i_imem_rdata}),
    .i_pop       (w_pop),
    .i_flush     (w_flush),
    .o_data      (w_fifo_dout),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_count     (w_occ)
  );

  assign o_imem_req    = w_req;
  assign o_imem_addr   = r_pc;
  assign o_dec_valid   = ~w_fifo_empty;
  assign {o_pc, o_instr} = w_fifo_dout;

  // A response with nothing in flight is a memory protocol error and is ignored
  a_no_orphan_rvalid: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_imem_rvalid && (r_out == '0)));

  // The request budget must never let a response arrive into a full buffer
  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
    !(w_push && w_fifo_full && !w_pop));
endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - randomized bench with queue-based reference model for instr_fetch
module tb_instr_fetch;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt = 1'b0;
  logic        i_imem_rvalid = 1'b0;
  logic [31:0] i_imem_rdata = '0;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = '0;
  logic        o_dec_valid;
  logic        i_dec_ready = 1'b0;
  logic [31:0] o_instr;
  logic [31:0] o_pc;

  instr_fetch #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_gnt    (i_imem_gnt),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_dec_valid   (o_dec_valid),
    .i_dec_ready   (i_dec_ready),
    .o_instr       (o_instr),
    .o_pc          (o_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } t_req;

  // Reference model: memory in-flight queue, decode-visible buffer, fetch PC, discard count
  t_req        req_q[$];
  logic [31:0] fifo_q[$];
  logic [31:0] mpc;
  int          drop;
  int          cyc;

  int n_checks;
  int n_errors;

  // Traffic settings
  int          lat_min, lat_max, gnt_pct, rdy_pct, redir_pct;
  logic        force_redir;
  logic [31:0] force_pc;

  function automatic logic [31:0] f_mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive inputs, compare every output against the model, then advance the model
  task automatic step();
    int  pop;
    bit  exp_req, grant, rv, redir;
    @(posedge clk);
    #1;
    i_imem_gnt  = ($urandom_range(99) < gnt_pct);
    i_dec_ready = ($urandom_range(99) < rdy_pct);
    redir       = force_redir || ($urandom_range(99) < redir_pct);
    i_redirect  = redir;
    if (force_redir)                  i_redirect_pc = force_pc;
    else if ($urandom_range(3) == 0)  i_redirect_pc = 32'hFFFF_FFF0 + $urandom_range(15);
    else                              i_redirect_pc = $urandom;
    rv = (req_q.size() > 0) && (req_q[0].due <= cyc);
    i_imem_rvalid = rv;
    i_imem_rdata  = rv ? f_mem(req_q[0].addr) : $urandom;
    @(negedge clk);

    pop     = (fifo_q.size() > 0 && i_dec_ready) ? 1 : 0;
    exp_req = (drop == 0) && ((req_q.size() + fifo_q.size() - pop) < DEPTH);
    chk("imem_req", {31'b0, o_imem_req}, {31'b0, exp_req});
    if (exp_req) chk("imem_addr", o_imem_addr, mpc);
    chk("dec_valid", {31'b0, o_dec_valid}, {31'b0, fifo_q.size() > 0});
    if (fifo_q.size() > 0) begin
      chk("dec_pc", o_pc, fifo_q[0]);
      chk("dec_instr", o_instr, f_mem(fifo_q[0]));
    end

    grant = exp_req && i_imem_gnt;
    if (pop != 0) void'(fifo_q.pop_front());
    if (rv) begin
      t_req r;
      r = req_q.pop_front();
      if (drop > 0)   drop--;
      else if (!redir) fifo_q.push_back(r.addr);
    end
    if (grant) begin
      req_q.push_back('{addr: mpc, due: cyc + $urandom_range(lat_max, lat_min)});
      mpc = mpc + 32'd4;
    end
    if (redir) begin
      fifo_q.delete();
      mpc  = {i_redirect_pc[31:2], 2'b00};
      drop = req_q.size();
    end
    cyc++;
  endtask

  // Asynchronous reset mid-cycle, then one IDLE cycle checked against reset values
  task automatic do_reset();
    @(posedge clk);
    #1;
    i_rst = 1'b1;
    i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0; i_redirect = 1'b0; i_dec_ready = 1'b0;
    #1;
    chk("rst_async_dec_valid", {31'b0, o_dec_valid}, 32'd0);
    chk("rst_async_imem_req", {31'b0, o_imem_req}, 32'd0);
    req_q.delete();
    fifo_q.delete();
    drop = 0;
    mpc  = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    i_rst = 1'b0;
    @(negedge clk);
    chk("idle_req", {31'b0, o_imem_req}, 32'd0);
    chk("idle_addr", o_imem_addr, 32'h0);
    chk("idle_dec_valid", {31'b0, o_dec_valid}, 32'd0);
    chk("idle_pc", o_pc, 32'h0);
    chk("idle_instr", o_instr, 32'h0);
  endtask

  task automatic set_traffic(input int lmin, input int lmax, input int g, input int r, input int rd);
    lat_min = lmin; lat_max = lmax; gnt_pct = g; rdy_pct = r; redir_pct = rd;
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (!o_dec_valid && k < 20) begin
      step();
      k++;
    end
    chk(name, {31'b0, o_dec_valid}, 32'd1);
  endtask

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0; drop = 0; mpc = 32'h0;
    force_redir = 1'b0; force_pc = '0;

    // 1: latency 1, always granted, always ready
    set_traffic(1, 1, 100, 100, 0);
    do_reset();
    step(); chk("t1_addr0", o_imem_addr, 32'h0);
    step(); chk("t1_addr1", o_imem_addr, 32'h4);
            chk("t1_novalid", {31'b0, o_dec_valid}, 32'd0);
    step(); chk("t1_valid3", {31'b0, o_dec_valid}, 32'd1);
            chk("t1_pc0", o_pc, 32'h0);
            chk("t1_addr2", o_imem_addr, 32'h8);
    step(); chk("t1_pc1", o_pc, 32'h4);
    step(); chk("t1_pc2", o_pc, 32'h8);
    repeat (5) step();
    // Stream is still full-rate and valid just before an asynchronous reset
    chk("t6_pre_valid", {31'b0, o_dec_valid}, 32'd1);
    chk("t6_pre_req", {31'b0, o_imem_req}, 32'd1);

    // 6 + 2: reset mid-stream, then decode stalled from the start
    set_traffic(1, 1, 100, 0, 0);
    do_reset();
    step(); chk("t2_addr0", o_imem_addr, 32'h0);
    step(); chk("t2_addr1", o_imem_addr, 32'h4);
    step(); chk("t2_stall_req", {31'b0, o_imem_req}, 32'd0);
    repeat (3) step();
    chk("t2_full_req", {31'b0, o_imem_req}, 32'd0);
    chk("t2_head_pc", o_pc, 32'h0);
    rdy_pct = 100;
    step(); chk("t2_pop0", o_pc, 32'h0);
            chk("t2_resume_addr", o_imem_addr, 32'h8);
    step(); chk("t2_pop1", o_pc, 32'h4);

    // 3: two in flight at latency 3, redirect to an unaligned target
    set_traffic(3, 3, 100, 100, 0);
    do_reset();
    step(); step();
    force_redir = 1'b1; force_pc = 32'h0000_0103;
    step();
    force_redir = 1'b0;
    step(); chk("t3_flush_req", {31'b0, o_imem_req}, 32'd0);
    step(); chk("t3_flush_req2", {31'b0, o_imem_req}, 32'd0);
    step(); chk("t3_restart_addr", o_imem_addr, 32'h100);
            chk("t3_restart_req", {31'b0, o_imem_req}, 32'd1);
    wait_valid("t3_valid");
    chk("t3_first_pc", o_pc, 32'h100);

    // 4: redirect coinciding with rvalid, grant and pop
    set_traffic(1, 1, 100, 100, 0);
    do_reset();
    step(); step();
    force_redir = 1'b1; force_pc = 32'h0000_0200;
    step();
    force_redir = 1'b0;
    chk("t4_rv", {31'b0, i_imem_rvalid}, 32'd1);
    chk("t4_req", {31'b0, o_imem_req}, 32'd1);
    chk("t4_pop", {31'b0, o_dec_valid}, 32'd1);
    step(); chk("t4_no_stale", {31'b0, o_dec_valid}, 32'd0);
    wait_valid("t4_valid");
    chk("t4_first_pc", o_pc, 32'h200);

    // 5: grant withheld for three cycles at address 0x8
    set_traffic(1, 1, 100, 100, 0);
    do_reset();
    step(); step();
    gnt_pct = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_hold_addr", o_imem_addr, 32'h8);
      chk("t5_hold_req", {31'b0, o_imem_req}, 32'd1);
    end
    gnt_pct = 100;
    step(); chk("t5_grant_addr", o_imem_addr, 32'h8);
    step(); chk("t5_next_addr", o_imem_addr, 32'hC);

    // Randomized traffic across several settings
    for (int ph = 0; ph < 6; ph++) begin
      set_traffic(1, 1 + ph % 4, 40 + 10 * ph, 30 + 12 * ph, 2 + ph);
      if (ph == 3) do_reset();
      repeat (600) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
